// File: rtl/branch_predictor_param.sv
// Parametrised BTB + saturating-counter direction table + global history.
// Same-cycle fetch prediction, EX-stage resolve/redirect, training and stats.
module branch_predictor_param #(
  parameter int IDX_BITS  = 6,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 0,
  parameter int STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_f,
  output logic                 pred_hit_f,
  output logic                 pred_taken_f,
  output logic [31:0]          pred_target_f,
  output logic [IDX_BITS-1:0]  pred_idx_f,
  input  logic                 upd_valid_e,
  input  logic [31:0]          upd_pc_e,
  input  logic [IDX_BITS-1:0]  upd_idx_e,
  input  logic                 upd_taken_e,
  input  logic [31:0]          upd_target_e,
  input  logic                 upd_pred_taken_e,
  input  logic [31:0]          upd_pred_target_e,
  output logic                 mispredict_e,
  output logic [31:0]          redirect_pc_e,
  input  logic                 flush_tables,
  output logic [STAT_BITS-1:0] br_cnt,
  output logic [STAT_BITS-1:0] miss_cnt
);

  localparam int N  = 1 << IDX_BITS;
  localparam int TW = 30 - IDX_BITS;
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1;

  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] WT   =
    CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] WNT  =
    CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

  logic [N-1:0]          validQ;
  logic [TW-1:0]         tagQ [N];
  logic [31:0]           tgtQ [N];
  logic [CTR_BITS-1:0]   ctrQ [N];
  logic [GW-1:0]         ghrQ;
  logic [STAT_BITS-1:0]  brQ;
  logic [STAT_BITS-1:0]  missQ;

  logic [IDX_BITS-1:0]   ghrExt;
  logic [IDX_BITS-1:0]   fIdx;
  logic [TW-1:0]         fTag;
  logic [IDX_BITS-1:0]   uIdx;
  logic [TW-1:0]         uTag;
  logic                  uHit;
  logic [CTR_BITS-1:0]   ctrNext;
  logic                  unusedBits;

  generate
    if (GHR_BITS > 0) begin : g_gshare
      assign ghrExt = IDX_BITS'(ghrQ);
    end else begin : g_bimodal
      assign ghrExt = '0;
    end
  endgenerate

  assign fIdx = pc_f[IDX_BITS+1:2];
  assign fTag = pc_f[31:IDX_BITS+2];
  assign uIdx = upd_pc_e[IDX_BITS+1:2];
  assign uTag = upd_pc_e[31:IDX_BITS+2];

  assign unusedBits = ^{pc_f[1:0], upd_pc_e[1:0], ghrQ};

  assign pred_idx_f    = fIdx ^ ghrExt;
  assign pred_hit_f    = validQ[fIdx] && (tagQ[fIdx] == fTag);
  assign pred_taken_f  = pred_hit_f &&
                         ctrQ[pred_idx_f][CTR_BITS-1];
  assign pred_target_f = pred_taken_f ? tgtQ[fIdx]
                                      : pc_f + 32'd4;

  assign uHit = validQ[uIdx] && (tagQ[uIdx] == uTag);

  // Redirect when direction differs or a taken target differs
  assign mispredict_e = rst && upd_valid_e &&
    ((upd_pred_taken_e != upd_taken_e) ||
     (upd_taken_e && upd_pred_taken_e &&
      (upd_pred_target_e != upd_target_e)));
  assign redirect_pc_e = upd_taken_e ? upd_target_e
                                     : upd_pc_e + 32'd4;

  assign br_cnt   = brQ;
  assign miss_cnt = missQ;

  // Saturating step of the counter selected by the carried index
  always_comb begin
    ctrNext = ctrQ[upd_idx_e];
    if (upd_taken_e) begin
      if (ctrNext != CMAX) ctrNext = ctrNext + CTR_BITS'(1);
    end else if (ctrNext != '0) begin
      ctrNext = ctrNext - CTR_BITS'(1);
    end
  end

  // Valid bits, direction counters and history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ <= '0;
      ghrQ   <= '0;
      for (int i = 0; i < N; i++) ctrQ[i] <= WNT;
    end else if (flush_tables) begin
      validQ <= '0;
      ghrQ   <= '0;
    end else if (upd_valid_e) begin
      ghrQ <= GW'({ghrQ, upd_taken_e});
      if (uHit) begin
        ctrQ[upd_idx_e] <= ctrNext;
      end else if (upd_taken_e) begin
        validQ[uIdx]    <= 1'b1;
        ctrQ[upd_idx_e] <= WT;
      end
    end
  end

  // Tag/target payload; only meaningful behind a valid bit
  always_ff @(posedge clk) begin
    if (upd_valid_e && !flush_tables && upd_taken_e) begin
      tagQ[uIdx] <= uTag;
      tgtQ[uIdx] <= upd_target_e;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brQ   <= '0;
      missQ <= '0;
    end else if (upd_valid_e) begin
      if (brQ != '1) brQ <= brQ + STAT_BITS'(1);
      if (mispredict_e && (missQ != '1))
        missQ <= missQ + STAT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_param.sv
// Bench for branch_predictor_param: directed cases plus random
// traffic against a table-level reference model; gshare side instance.
module tb_branch_predictor_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pcF;
  logic        predHitF, predTakenF;
  logic [31:0] predTargetF;
  logic [5:0]  predIdxF;
  logic        updValidE, updTakenE, updPredTakenE, flushT;
  logic [31:0] updPcE, updTargetE, updPredTargetE;
  logic [5:0]  updIdxE;
  logic        mispredE;
  logic [31:0] redirectE;
  logic [31:0] brCnt, missCnt;

  logic [31:0] gPcF;
  logic        gHitF, gTakenF;
  logic [31:0] gTargetF;
  logic [5:0]  gIdxF;
  logic        gUv, gUt, gUpt;
  logic [31:0] gUpc, gUtgt, gUptgt;
  logic [5:0]  gUidx;
  logic        gMis;
  logic [31:0] gRedir;
  logic [3:0]  gBr, gMiss;

  branch_predictor_param u_dut (
    .clk(clk), .rst(rst), .pc_f(pcF),
    .pred_hit_f(predHitF), .pred_taken_f(predTakenF),
    .pred_target_f(predTargetF), .pred_idx_f(predIdxF),
    .upd_valid_e(updValidE), .upd_pc_e(updPcE),
    .upd_idx_e(updIdxE), .upd_taken_e(updTakenE),
    .upd_target_e(updTargetE),
    .upd_pred_taken_e(updPredTakenE),
    .upd_pred_target_e(updPredTargetE),
    .mispredict_e(mispredE), .redirect_pc_e(redirectE),
    .flush_tables(flushT), .br_cnt(brCnt), .miss_cnt(missCnt)
  );

  branch_predictor_param #(.GHR_BITS(2), .STAT_BITS(4)) u_gs (
    .clk(clk), .rst(rst), .pc_f(gPcF),
    .pred_hit_f(gHitF), .pred_taken_f(gTakenF),
    .pred_target_f(gTargetF), .pred_idx_f(gIdxF),
    .upd_valid_e(gUv), .upd_pc_e(gUpc),
    .upd_idx_e(gUidx), .upd_taken_e(gUt),
    .upd_target_e(gUtgt),
    .upd_pred_taken_e(gUpt),
    .upd_pred_target_e(gUptgt),
    .mispredict_e(gMis), .redirect_pc_e(gRedir),
    .flush_tables(1'b0), .br_cnt(gBr), .miss_cnt(gMiss)
  );

  int nTests = 0;
  int nFail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one entry per BTB slot, counters as integers
  bit          mValid [64];
  logic [23:0] mTag   [64];
  logic [31:0] mTgt   [64];
  int          mCtr   [64];
  longint      mBr, mMiss;

  function automatic void mReset();
    for (int i = 0; i < 64; i++) begin
      mValid[i] = 0;
      mCtr[i]   = 1;
    end
    mBr   = 0;
    mMiss = 0;
  endfunction

  function automatic void mPredict(input logic [31:0] pc,
                                   output bit hit,
                                   output bit tk,
                                   output logic [31:0] tgt);
    int i;
    i   = int'(pc[7:2]);
    hit = mValid[i] && (mTag[i] == pc[31:8]);
    tk  = hit && (mCtr[i] >= 2);
    tgt = tk ? mTgt[i] : pc + 32'd4;
  endfunction

  function automatic bit mMis();
    return updValidE &&
      ((updPredTakenE != updTakenE) ||
       (updTakenE && updPredTakenE &&
        (updPredTargetE != updTargetE)));
  endfunction

  task automatic drive(input logic [31:0] pc, input bit uv,
                       input logic [31:0] upc, input logic [5:0] uidx,
                       input bit ut, input logic [31:0] utgt,
                       input bit upt, input logic [31:0] uptgt,
                       input bit fl);
    @(negedge clk);
    pcF            = pc;
    updValidE      = uv;
    updPcE         = upc;
    updIdxE        = uidx;
    updTakenE      = ut;
    updTargetE     = utgt;
    updPredTakenE  = upt;
    updPredTargetE = uptgt;
    flushT         = fl;
    #1;
  endtask

  task automatic modelCheck();
    bit hit, tk;
    logic [31:0] tgt;
    mPredict(pcF, hit, tk, tgt);
    check("hit", predHitF, hit);
    check("taken", predTakenF, tk);
    check("target", predTargetF, tgt);
    check("idx", predIdxF, pcF[7:2]);
    check("mispredict", mispredE, mMis());
    if (updValidE)
      check("redirect", redirectE,
            updTakenE ? updTargetE : updPcE + 32'd4);
    check("br_cnt", brCnt, mBr);
    check("miss_cnt", missCnt, mMiss);
  endtask

  task automatic commit();
    int b, c;
    bit hit;
    if (updValidE) begin
      if (mMis()) mMiss++;
      mBr++;
    end
    if (flushT) begin
      for (int i = 0; i < 64; i++) mValid[i] = 0;
    end else if (updValidE) begin
      b   = int'(updPcE[7:2]);
      c   = int'(updIdxE);
      hit = mValid[b] && (mTag[b] == updPcE[31:8]);
      if (hit) begin
        if (updTakenE) begin
          mCtr[c] = (mCtr[c] < 3) ? mCtr[c] + 1 : 3;
          mTgt[b] = updTargetE;
        end else begin
          mCtr[c] = (mCtr[c] > 0) ? mCtr[c] - 1 : 0;
        end
      end else if (updTakenE) begin
        mValid[b] = 1;
        mTag[b]   = updPcE[31:8];
        mTgt[b]   = updTargetE;
        mCtr[c]   = 2;
      end
    end
  endtask

  logic [31:0] pool [8];
  logic [31:0] tgts [4];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc, upc, utgt, ptgt;
    logic [5:0]  uidx;
    bit          uv, ut, pt, fl, h;
    int          gCtr [4];
    bit          gAlloc;
    int          gGhr, gBrM, gMissM, prevIdx;
    bit          eTk, eMis;

    pool = '{32'h100, 32'h104, 32'h108, 32'h200,
             32'h1104, 32'h3FC, 32'h400, 32'h10C};
    tgts = '{32'h40, 32'h80, 32'h1000, 32'h2468};

    rst = 1'b0;
    pcF = 32'h100;
    updValidE = 1'b1; updPcE = 32'h100; updIdxE = '0;
    updTakenE = 1'b0; updTargetE = 32'h40;
    updPredTakenE = 1'b1; updPredTargetE = 32'h40;
    flushT = 1'b0;
    gPcF = 32'h100; gUv = 1'b0; gUpc = 32'h100; gUidx = '0;
    gUt = 1'b0; gUtgt = 32'h40; gUpt = 1'b0; gUptgt = 32'h104;
    #1;
    check("rst_hit", predHitF, 0);
    check("rst_taken", predTakenF, 0);
    check("rst_target", predTargetF, 32'h104);
    check("rst_mispredict", mispredE, 0);
    check("rst_br", brCnt, 0);
    check("rst_miss", missCnt, 0);
    updValidE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mReset();

    // cold taken branch
    drive(32'h100, 1, 32'h100, 6'd0, 1, 32'h40, 0, 32'h104, 0);
    check("cold_mis", mispredE, 1);
    check("cold_redir", redirectE, 32'h40);
    check("cold_nobypass", predHitF, 0);
    modelCheck(); commit();
    drive(32'h100, 1, 32'h100, 6'd0, 0, 32'h40, 1, 32'h40, 0);
    check("alloc_hit", predHitF, 1);
    check("alloc_taken", predTakenF, 1);
    check("alloc_tgt", predTargetF, 32'h40);
    check("nt1_mis", mispredE, 1);
    check("nt1_redir", redirectE, 32'h104);
    modelCheck(); commit();
    drive(32'h100, 1, 32'h100, 6'd0, 0, 32'h40, 0, 32'h104, 0);
    check("nt2_taken", predTakenF, 0);
    check("nt2_mis", mispredE, 0);
    modelCheck(); commit();
    drive(32'h200, 0, 32'h0, 6'd0, 0, 32'h0, 0, 32'h0, 0);
    check("alias_hit", predHitF, 0);
    modelCheck(); commit();
    drive(32'h100, 0, 32'h0, 6'd0, 0, 32'h0, 0, 32'h0, 0);
    check("sat_hit", predHitF, 1);
    check("sat_tgt", predTargetF, 32'h104);
    modelCheck(); commit();
    drive(32'h100, 1, 32'h100, 6'd0, 1, 32'h40, 0, 32'h104, 0);
    modelCheck(); commit();
    drive(32'h100, 0, 32'h0, 6'd0, 0, 32'h0, 0, 32'h0, 0);
    check("sat_floor", predTakenF, 0);
    modelCheck(); commit();
    drive(32'h100, 1, 32'h300, 6'd0, 1, 32'h80, 0, 32'h304, 1);
    modelCheck(); commit();
    drive(32'h300, 0, 32'h0, 6'd0, 0, 32'h0, 0, 32'h0, 0);
    check("flush_noalloc", predHitF, 0);
    check("flush_br", brCnt, 5);
    check("flush_miss", missCnt, 4);
    modelCheck(); commit();
    drive(32'h100, 0, 32'h0, 6'd0, 0, 32'h0, 0, 32'h0, 0);
    check("flush_clr", predHitF, 0);
    modelCheck(); commit();

    // reset in the middle of an update
    drive(32'h500, 1, 32'h500, 6'd0, 1, 32'h80, 0, 32'h504, 0);
    modelCheck();
    #1;
    rst = 1'b0;
    #1;
    check("arst_br", brCnt, 0);
    check("arst_miss", missCnt, 0);
    check("arst_mis", mispredE, 0);
    check("arst_tgt", predTargetF, 32'h504);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mReset();
    drive(32'h500, 0, 32'h0, 6'd0, 0, 32'h0, 0, 32'h0, 0);
    check("arst_drop", predHitF, 0);
    modelCheck(); commit();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      pc   = pool[$urandom_range(0, 7)];
      uv   = ($urandom_range(0, 3) != 0);
      upc  = pool[$urandom_range(0, 7)];
      uidx = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                        : upc[7:2];
      ut   = 1'($urandom_range(0, 1));
      utgt = tgts[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        mPredict(upc, h, pt, ptgt);
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = tgts[$urandom_range(0, 3)];
      end
      fl = ($urandom_range(0, 39) == 0);
      drive(pc, uv, upc, uidx, ut, utgt, pt, ptgt, fl);
      modelCheck();
      commit();
    end
    @(negedge clk);
    updValidE = 1'b0;
    flushT    = 1'b0;

    // gshare instance: alternating branch at 0x100
    for (int i = 0; i < 4; i++) gCtr[i] = 1;
    gAlloc = 0; gGhr = 0; gBrM = 0; gMissM = 0; prevIdx = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gUv = 1'b0;
      gPcF = 32'h100;
      #1;
      check("gs_idx", gIdxF, gGhr);
      if (i > 0) check("gs_idx_alt", gIdxF != 6'(prevIdx), 1);
      prevIdx = gGhr;
      eTk = gAlloc && (gCtr[gGhr] >= 2);
      check("gs_taken", gTakenF, eTk);
      gUv    = 1'b1;
      gUpc   = 32'h100;
      gUidx  = gIdxF;
      gUt    = (i % 2 == 0);
      gUtgt  = 32'h40;
      gUpt   = gTakenF;
      gUptgt = gTargetF;
      #1;
      eMis = (eTk != gUt) || (gUt && eTk && gUptgt != 32'h40);
      check("gs_mis", gMis, eMis);
      check("gs_br", gBr, gBrM);
      check("gs_miss", gMiss, gMissM);
      gBrM = (gBrM < 15) ? gBrM + 1 : 15;
      if (eMis && gMissM < 15) gMissM++;
      if (gAlloc) begin
        if (gUt) gCtr[gGhr] = (gCtr[gGhr] < 3) ? gCtr[gGhr] + 1 : 3;
        else     gCtr[gGhr] = (gCtr[gGhr] > 0) ? gCtr[gGhr] - 1 : 0;
      end else if (gUt) begin
        gAlloc = 1;
        gCtr[gGhr] = 2;
      end
      gGhr = ((gGhr << 1) | int'(gUt)) & 3;
    end
    @(negedge clk);
    gUv = 1'b0;
    #1;
    check("gs_br_sat", gBr, 15);
    check("gs_miss_warm", gMiss, 2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
